bcd_counter_7seg_mux: RTL and testbench

Parametrised N-digit BCD up/down counter with a time-multiplexed, active-low 7-segment display driver.
- Generalises the fixed 4-digit up-counter: configurable digit count, anode width, tick and scan rates.
- Adds direction control, synchronous load/clear, wrap flag and optional leading-zero blanking.
- Sits at board top level: drives the seg/an display pins; count is also exported to other logic.

---
 rtl/bcd7seg_pkg.sv | 21 ++
 rtl/bcd_digit_cell.sv | 34 +++
 rtl/bcd_counter_7seg_mux.sv | 124 ++++++++++++
 tb/tb_bcd_counter_7seg_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd7seg_pkg.sv
// Shared segment encodings and BCD helpers for the multiplexed 7-segment counter.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package bcd7seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  function automatic logic [3:0] sat_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter; carry_out doubles as the borrow when counting down.
module bcd_digit_cell
  import bcd7seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       up_dn,
  input  logic       step_in,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic at_limit;

  assign at_limit  = up_dn ? (digit == 4'd9) : (digit == 4'd0);
  assign carry_out = step_in && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= sat_bcd(load_digit);
    end else if (step_in) begin
      if (up_dn) digit <= at_limit ? 4'd0 : digit + 4'd1;
      else       digit <= at_limit ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// N-digit BCD up/down counter with a free-running, time-multiplexed active-low
// 7-segment driver and optional leading-zero blanking.
module bcd_counter_7seg_mux
  import bcd7seg_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_DIV   = 100_000,
  parameter int NUM_DIGITS = 4,
  parameter int AN_WIDTH   = 8,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [AN_WIDTH-1:0]     an
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > AN_WIDTH) begin : g_bad_digits
    $error("bcd_counter_7seg_mux: NUM_DIGITS must be in 1..AN_WIDTH");
  end
  if (TICK_DIV < 1) begin : g_bad_tick
    $error("bcd_counter_7seg_mux: CLK_FREQ/TICK_HZ must be >= 1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("bcd_counter_7seg_mux: SCAN_DIV must be >= 1");
  end

  logic [TICK_W-1:0]     tick_cnt;
  logic                  step;
  logic [NUM_DIGITS:0]   carry;

  assign step = en && (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tick_cnt <= '0;
    else if (clear || load) tick_cnt <= '0;
    else if (en)            tick_cnt <= step ? '0 : tick_cnt + TICK_W'(1);
  end

  // Ripple chain: a digit steps only when every lower digit is at its limit.
  assign carry[0] = step && !clear && !load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .up_dn      (up_dn),
      .step_in    (carry[i]),
      .load       (load),
      .clear      (clear),
      .load_digit (load_val[4*i +: 4]),
      .digit      (count[4*i +: 4]),
      .carry_out  (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= carry[NUM_DIGITS];
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // zero_from[i]: digits i..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [AN_WIDTH-1:0]   an_next;

  always_comb begin
    zero_from = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_next   = '1;
    zero_from[NUM_DIGITS-1] = (count[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (count[4*i +: 4] == 4'd0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit  = count[4*i +: 4];
        cur_blank  = (BLANK_LZ != 0) && (i > 0) && zero_from[i];
        an_next[i] = cur_blank;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= cur_blank ? SEG_BLANK : seg_decode(cur_digit);
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Directed scoreboard bench for the 4-digit BCD counter and 7-segment scan driver.
module tb_bcd_counter_7seg_mux;

  logic        clk = 1'b0;
  logic        reset, en, up_dn, load, clear;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  seg;
  logic [7:0]  an;

  int vectors     = 0;
  int miscompares = 0;
  int edges       = 0;

  logic [31:0] sb_q [$];

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  bcd_counter_7seg_mux #(
    .CLK_FREQ   (10),
    .TICK_HZ    (1),
    .SCAN_DIV   (2),
    .NUM_DIGITS (4),
    .AN_WIDTH   (8),
    .BLANK_LZ   (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .clear    (clear),
    .count    (count),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Expected {an,seg} for the display state latched on edge e after reset release.
  function automatic logic [31:0] exp_scan(input int e, input logic [15:0] cnt);
    int          idx;
    logic [3:0]  d;
    logic [15:0] upper;
    logic [7:0]  a;
    logic [6:0]  s;
    idx   = ((e - 1) / 2) % 4;
    d     = cnt[idx*4 +: 4];
    upper = cnt >> (idx * 4);
    if (idx > 0 && upper == 16'd0) begin
      a = 8'hFF;
      s = 7'h7F;
    end else begin
      a = ~(8'h01 << idx);
      s = segtab[d];
    end
    return {17'd0, a, s};
  endfunction

  task automatic scan_check(input string tag, input logic [15:0] cnt, input int n);
    for (int k = 0; k < n; k++) begin
      push(exp_scan(edges + 1, cnt));
      clk_n(1);
      check_pop(tag, {17'd0, an, seg});
    end
  endtask

  task automatic chk_count(input string tag, input logic [15:0] c, input logic w);
    push({16'd0, c});
    check_pop({tag, "_count"}, {16'd0, count});
    push({31'd0, w});
    check_pop({tag, "_wrap"}, {31'd0, wrap});
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    clk_n(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; clear = 1'b0; load_val = '0;
    #2 reset = 1'b1;
    #1;
    chk_count("reset", 16'h0000, 1'b0);
    push({25'd0, 7'h7F}); check_pop("reset_seg", {25'd0, seg});
    push({24'd0, 8'hFF}); check_pop("reset_an", {24'd0, an});
    #1 reset = 1'b0; en = 1'b1;

    push(exp_scan(1, 16'h0000)); clk_n(1);
    check_pop("first_edge_scan", {17'd0, an, seg});
    for (int k = 2; k <= 149; k++) begin
      push(32'hF); clk_n(1);
      check_pop("an_upper", {28'd0, an[7:4]});
    end
    chk_count("run149", 16'h0014, 1'b0);
    clk_n(1);
    chk_count("run150", 16'h0015, 1'b0);

    do_load(16'h9998);
    chk_count("load9998", 16'h9998, 1'b0);
    clk_n(10);
    chk_count("up_tick1", 16'h9999, 1'b0);
    clk_n(9);
    chk_count("up_pre_wrap", 16'h9999, 1'b0);
    clk_n(1);
    chk_count("up_wrap", 16'h0000, 1'b1);
    clk_n(1);
    chk_count("up_wrap_end", 16'h0000, 1'b0);

    up_dn = 1'b0;
    do_load(16'h0000);
    clk_n(10);
    chk_count("down_wrap", 16'h9999, 1'b1);
    do_load(16'h1000);
    clk_n(10);
    chk_count("down_borrow", 16'h0999, 1'b0);

    en = 1'b0;
    do_load(16'h0042); clk_n(1);
    scan_check("blank_0042", 16'h0042, 8);
    do_load(16'h0000); clk_n(1);
    scan_check("blank_0000", 16'h0000, 8);
    do_load(16'h1234); clk_n(1);
    scan_check("scan_1234", 16'h1234, 8);

    en = 1'b1; up_dn = 1'b1;
    do_load(16'h0500);
    clk_n(9);
    load = 1'b1; clear = 1'b1; load_val = 16'h0700;
    clk_n(1);
    load = 1'b0; clear = 1'b0;
    chk_count("clear_prio", 16'h0000, 1'b0);
    clk_n(9);
    do_load(16'h0700);
    chk_count("load_prio", 16'h0700, 1'b0);
    clk_n(10);
    chk_count("after_load_step", 16'h0701, 1'b0);

    en = 1'b0;
    do_load(16'hA5F3);
    chk_count("saturate", 16'h9593, 1'b0);
    for (int k = 0; k < 5; k++) begin
      clk_n(10);
      chk_count("frozen", 16'h9593, 1'b0);
    end
    scan_check("frozen_scan", 16'h9593, 8);

    clk_n(1);
    #3 reset = 1'b1;
    #1;
    chk_count("async_reset", 16'h0000, 1'b0);
    push({25'd0, 7'h7F}); check_pop("async_seg", {25'd0, seg});
    push({24'd0, 8'hFF}); check_pop("async_an", {24'd0, an});
    #1 reset = 1'b0;
    scan_check("post_reset_scan", 16'h0000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
